pipe_manager: RTL
=================

# pipe_manager

Game-state engine for the flappy-bird design, running on the divided game clock. Owns pipe scrolling, pseudo-random gap heights, bird-vs-pipe collision, scoring and the IDLE/PLAY/DEAD state machine. Produces the pipe coordinates consumed by the display manager and takes the bird coordinates produced by the bird-physics block. Replaces the hard-wired pipe positions in the top level.

## Interface
Parameters:
- SCREEN_W, 640: horizontal pixels; pipe x wraps to SCREEN_W-1.
- SCREEN_H, 480: vertical pixels; floor collision limit.
- PIPE_W, 40: pipe width in pixels.
- GAP_H, 100: vertical gap height in pixels.
- BIRD_SIZE, 10: bird bounding-box edge in pixels.
- Y_MIN, 60: smallest gap-top y.
- INIT_Y1, 250 / INIT_Y2, 200: gap-top y of pipe 1 / pipe 2 after reset.
- LFSR_SEED, 16'hACE1: LFSR reset value; must be non-zero.

Ports:
- game_clk, in, 1: game clock; all state changes on its rising edge.
- reset, in, 1: synchronous, active-high.
- enable, in, 1: pause control; pipes move only when high.
- start, in, 1: level, sampled each cycle. IDLE->PLAY; DEAD->IDLE.
- bird_x, in, 11: bird left edge.
- bird_y, in, 11: bird top edge.
- pipe1_x, pipe2_x, out, 11: pipe left edges.
- pipe1_y, pipe2_y, out, 11: gap top; gap spans y..y+GAP_H-1.
- score, out, 10: pipes passed, binary, saturates at 999.
- playing, out, 1: high in PLAY.
- game_over, out, 1: high in DEAD.

## Operation
- Reset values: pipe1_x=319, pipe2_x=639, pipe1_y=INIT_Y1, pipe2_y=INIT_Y2, score=0, state=IDLE, playing=0, game_over=0, lfsr=LFSR_SEED.
- LFSR: 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1. Shifts every cycle except during reset, in all states.
- New gap y: r = lfsr[8:0]. If r<320, y = Y_MIN+r; else y = Y_MIN+r-320. Result is always in 60..379.
- IDLE: pipes and score hold. start=1 -> PLAY.
- PLAY, enable=0: all state holds; collision is still evaluated.
- PLAY, enable=1: each pipe is handled independently, both in the same cycle if needed.
  - pipe_x==0: x <= SCREEN_W-1 and y <= new gap y.
  - Otherwise: x <= x-1.
- Score: increments by 1 when enable=1 and pipe_x+PIPE_W == bird_x for either pipe. If both pipes match, it still increments by 1 only. Holds at 999.
- Collision, combinational on current values:
  - Pipe hit: x overlap [bird_x, bird_x+BIRD_SIZE-1] ∩ [pipe_x, pipe_x+PIPE_W-1] ≠ ∅ AND (bird_y < pipe_y OR bird_y+BIRD_SIZE-1 > pipe_y+GAP_H-1).
  - Floor hit: bird_y+BIRD_SIZE-1 >= SCREEN_H.
- PLAY with collision -> DEAD. Collision has priority over scoring and movement in that cycle: score and pipes hold.
- DEAD: everything frozen, score retained. start=1 -> IDLE; pipes and gap y reload to reset values, score=0, lfsr keeps running.
- All arithmetic is 11-bit unsigned. Comparisons use 12-bit intermediates so that x+PIPE_W cannot overflow.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Collision to game_over=1 and playing=0: 1 cycle.
- start to playing=1: 1 cycle.
- One pixel of pipe movement per enabled PLAY cycle. A pipe completes a full traverse in SCREEN_W cycles.
- Reset mid-PLAY or mid-DEAD: outputs take reset values on the next edge, regardless of start, enable or collision.
- start held high through DEAD->IDLE does not re-enter PLAY in the same cycle. IDLE needs start sampled high on a later cycle; holding start high gives PLAY 2 cycles after DEAD.

## Test plan
- Reset, then hold start=0 and enable=1 for 50 cycles -> pipe1_x=319, pipe2_x=639, score=0, playing=0, game_over=0 throughout.
- start=1 for 1 cycle, enable=1, bird at (100,250) inside the pipe-1 gap -> pipe1_x decrements 1 per cycle. At the cycle where pipe1_x+40==100, score goes 0->1 and game_over stays 0.
- Pipe wrap: run until pipe1_x==0 -> next cycle pipe1_x=639 and pipe1_y=Y_MIN+(lfsr[8:0] mod 320), checked against a bench LFSR model.
- Bird (100,150) with pipe1_y=250 while pipe1_x moves to 109 -> the x-overlap cycle sets DEAD. game_over=1 one cycle later, pipes freeze and score is unchanged.
- Floor: bird_y=471 in PLAY -> game_over=1 next cycle. Then start=1 -> IDLE with pipe1_x=319, score=0. A second start -> PLAY.
- In PLAY with enable=0 for 20 cycles -> pipes hold. Assert reset mid-PLAY -> all outputs at reset values on the next edge.

Source files
------------

// File: rtl/pipe_manager.sv
// Flappy-bird game-state engine: pipe scrolling, gap heights, collision,
// scoring and the IDLE/PLAY/DEAD state machine on the game clock.
module pipe_manager #(
    parameter int SCREEN_W  = 640,
    parameter int SCREEN_H  = 480,
    parameter int PIPE_W    = 40,
    parameter int GAP_H     = 100,
    parameter int BIRD_SIZE = 10,
    parameter int Y_MIN     = 60,
    parameter int INIT_Y1   = 250,
    parameter int INIT_Y2   = 200,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        game_clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        start,
    input  logic [10:0] bird_x,
    input  logic [10:0] bird_y,
    output logic [10:0] pipe1_x,
    output logic [10:0] pipe2_x,
    output logic [10:0] pipe1_y,
    output logic [10:0] pipe2_y,
    output logic [9:0]  score,
    output logic        playing,
    output logic        game_over
);

    typedef enum logic [1:0] {IDLE, PLAY, DEAD} state_t;

    localparam logic [10:0] X1_RST  = 11'(SCREEN_W / 2 - 1);
    localparam logic [10:0] X2_RST  = 11'(SCREEN_W - 1);
    localparam logic [10:0] Y1_RST  = 11'(INIT_Y1);
    localparam logic [10:0] Y2_RST  = 11'(INIT_Y2);
    localparam logic [10:0] Y_MIN11 = 11'(Y_MIN);
    localparam logic [11:0] BS_M1   = 12'(BIRD_SIZE - 1);
    localparam logic [11:0] PW      = 12'(PIPE_W);
    localparam logic [11:0] PW_M1   = 12'(PIPE_W - 1);
    localparam logic [11:0] GH_M1   = 12'(GAP_H - 1);
    localparam logic [11:0] FLOOR   = 12'(SCREEN_H);
    localparam logic [9:0]  SCORE_MAX = 10'd999;

    state_t      state, state_nx;
    logic [15:0] lfsr;
    logic [10:0] p1x_nx, p2x_nx, p1y_nx, p2y_nx;
    logic [9:0]  score_nx;
    logic [10:0] gap_y;
    logic [8:0]  r;
    logic        hit1, hit2, floor_hit, collide;
    logic        match1, match2;

    function automatic logic pipe_hit(input logic [10:0] bx, input logic [10:0] by,
                                      input logic [10:0] px, input logic [10:0] py);
        logic [11:0] bl, br, bt, bb, pl, pr, gt, gb;
        logic        x_ov, y_out;
        bl    = {1'b0, bx};
        br    = bl + BS_M1;
        bt    = {1'b0, by};
        bb    = bt + BS_M1;
        pl    = {1'b0, px};
        pr    = pl + PW_M1;
        gt    = {1'b0, py};
        gb    = gt + GH_M1;
        x_ov  = (bl <= pr) && (pl <= br);
        y_out = (bt < gt) || (bb > gb);
        return x_ov && y_out;
    endfunction

    assign r     = lfsr[8:0];
    assign gap_y = (r < 9'd320) ? Y_MIN11 + {2'b0, r}
                                : Y_MIN11 + {2'b0, r} - 11'd320;

    assign hit1      = pipe_hit(bird_x, bird_y, pipe1_x, pipe1_y);
    assign hit2      = pipe_hit(bird_x, bird_y, pipe2_x, pipe2_y);
    assign floor_hit = ({1'b0, bird_y} + BS_M1) >= FLOOR;
    assign collide   = hit1 || hit2 || floor_hit;

    assign match1 = ({1'b0, pipe1_x} + PW) == {1'b0, bird_x};
    assign match2 = ({1'b0, pipe2_x} + PW) == {1'b0, bird_x};

    always_comb begin
        state_nx = state;
        p1x_nx   = pipe1_x;
        p2x_nx   = pipe2_x;
        p1y_nx   = pipe1_y;
        p2y_nx   = pipe2_y;
        score_nx = score;
        unique case (state)
            IDLE: begin
                if (start) state_nx = PLAY;
            end
            PLAY: begin
                // collision freezes the world for this cycle
                if (collide) begin
                    state_nx = DEAD;
                end else if (enable) begin
                    if (pipe1_x == 11'd0) begin
                        p1x_nx = X2_RST;
                        p1y_nx = gap_y;
                    end else begin
                        p1x_nx = pipe1_x - 11'd1;
                    end
                    if (pipe2_x == 11'd0) begin
                        p2x_nx = X2_RST;
                        p2y_nx = gap_y;
                    end else begin
                        p2x_nx = pipe2_x - 11'd1;
                    end
                    if ((match1 || match2) && score != SCORE_MAX)
                        score_nx = score + 10'd1;
                end
            end
            DEAD: begin
                if (start) begin
                    state_nx = IDLE;
                    p1x_nx   = X1_RST;
                    p2x_nx   = X2_RST;
                    p1y_nx   = Y1_RST;
                    p2y_nx   = Y2_RST;
                    score_nx = 10'd0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge game_clk) begin
        if (reset) begin
            state   <= IDLE;
            lfsr    <= LFSR_SEED;
            pipe1_x <= X1_RST;
            pipe2_x <= X2_RST;
            pipe1_y <= Y1_RST;
            pipe2_y <= Y2_RST;
            score   <= 10'd0;
        end else begin
            state   <= state_nx;
            lfsr    <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            pipe1_x <= p1x_nx;
            pipe2_x <= p2x_nx;
            pipe1_y <= p1y_nx;
            pipe2_y <= p2y_nx;
            score   <= score_nx;
        end
    end

    assign playing   = (state == PLAY);
    assign game_over = (state == DEAD);

endmodule
